// File: rtl/fbuf_scanout_if.sv
// Framebuffer scan-out bundle: BRAM read port plus video encoder outputs.
//   master: scan-out engine (drives read request and video, receives read data)
//   slave : BRAM/encoder side (drives read data, receives everything else)
interface fbuf_scanout_if #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8
);
  logic                       fbuf_en_rd;
  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
  logic [FBUF_DATA_WIDTH-1:0] fbuf_data;
  logic                       vid_de;
  logic                       vid_hsync;
  logic                       vid_vsync;
  logic [23:0]                vid_rgb;
  logic                       frame_start;

  modport master (
    output fbuf_en_rd, fbuf_addr, vid_de, vid_hsync, vid_vsync, vid_rgb, frame_start,
    input  fbuf_data
  );

  modport slave (
    input  fbuf_en_rd, fbuf_addr, vid_de, vid_hsync, vid_vsync, vid_rgb, frame_start,
    output fbuf_data
  );
endinterface

// File: rtl/fbuf_scanout.sv
// Framebuffer scan-out: generates VGA-style timing, reads RGB332 pixels from
// the framebuffer BRAM and emits aligned RGB888/DE/HSYNC/VSYNC.
// Ports:
//   clk, rst_n : pixel clock, async active-low reset
//   pix_en     : pixel clock enable; all state advances only when high
//   bus        : fbuf_en_rd/fbuf_addr/fbuf_data BRAM read port,
//                vid_de/vid_hsync/vid_vsync/vid_rgb/frame_start video outputs
module fbuf_scanout #(
  parameter int unsigned FBUF_ADDR_WIDTH = 19,
  parameter int unsigned FBUF_DATA_WIDTH = 8,
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter bit          SYNC_POL        = 1'b0,
  parameter int unsigned RD_LATENCY      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  fbuf_scanout_if.master   bus
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_VISIBLE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned TAG_W    = 4;

  logic [H_W-1:0]             h_cnt;
  logic [V_W-1:0]             v_cnt;
  logic [FBUF_ADDR_WIDTH-1:0] addr_cnt;
  logic                       h_last, v_last;
  logic                       de0, hs0, vs0, st0;
  logic [TAG_W-1:0]           pipe [RD_LATENCY];
  logic [TAG_W-1:0]           tap;
  logic [23:0]                rgb_c;
  logic [7:0]                 d;

  // Stage-0 raw timing decoded from the counters
  always_comb begin
    h_last = (h_cnt == H_W'(H_TOTAL - 1));
    v_last = (v_cnt == V_W'(V_TOTAL - 1));
    de0    = (h_cnt < H_W'(H_VISIBLE)) && (v_cnt < V_W'(V_VISIBLE));
    hs0    = (h_cnt >= H_W'(HS_FIRST)) && (h_cnt <= H_W'(HS_LAST));
    vs0    = (v_cnt >= V_W'(VS_FIRST)) && (v_cnt <= V_W'(VS_LAST));
    st0    = (h_cnt == '0) && (v_cnt == '0);
  end

  // Raster counters and running linear read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + H_W'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
      if (h_last && v_last) addr_cnt <= '0;
      else if (de0)         addr_cnt <= addr_cnt + FBUF_ADDR_WIDTH'(1);
    end
  end

  // Read request is live only on enabled visible cycles; rst_n keeps it low
  // while the counters sit at the (0,0) visible position in reset.
  assign bus.fbuf_en_rd = de0 && pix_en && rst_n;
  assign bus.fbuf_addr  = addr_cnt;

  // Timing tags delayed to line up with BRAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) pipe[i] <= '0;
    end else if (pix_en) begin
      pipe[0] <= {de0, hs0, vs0, st0};
      for (int i = 1; i < int'(RD_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tap = pipe[RD_LATENCY-1];

  // RGB332 to RGB888 by bit replication; blanked outside the visible area
  always_comb begin
    d     = bus.fbuf_data[7:0];
    rgb_c = '0;
    if (tap[3]) rgb_c = {d[7:5], d[7:5], d[7:6],
                         d[4:2], d[4:2], d[4:3],
                         d[1:0], d[1:0], d[1:0], d[1:0]};
  end

  // Final output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vid_de      <= 1'b0;
      bus.vid_hsync   <= ~SYNC_POL;
      bus.vid_vsync   <= ~SYNC_POL;
      bus.vid_rgb     <= '0;
      bus.frame_start <= 1'b0;
    end else if (pix_en) begin
      bus.vid_de      <= tap[3];
      bus.vid_hsync   <= tap[2] ? SYNC_POL : ~SYNC_POL;
      bus.vid_vsync   <= tap[1] ? SYNC_POL : ~SYNC_POL;
      bus.vid_rgb     <= rgb_c;
      bus.frame_start <= tap[0];
    end
  end

endmodule
